// File: rtl/ram_access_ctrl.sv
// ram_access_ctrl: core-side load/store controller for a synchronous RAM with an in-order response FIFO.
// Latency: RAM ports are driven 1 cycle after accept, and a load response reaches the FIFO head 3 cycles after accept.
// Backpressure: ReqReady drops while RESP_DEPTH responses are outstanding; RespReady low holds the FIFO head.
// Option: define WRITE_ACK_EN so that stores also return a write acknowledge through the FIFO.

// ram_access_ctrl_fifo: generic synchronous FIFO with a show-ahead head.
// Latency: a pushed entry is visible at the head on the cycle after the push.
// Backpressure: the caller must never push when full; out_rdy low holds the head.
module ram_access_ctrl_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic             gclk,
   input  logic             greset,
   input  logic             in_vld,
   input  logic [WIDTH-1:0] in_dat,
   output logic             out_vld,
   input  logic             out_rdy,
   output logic [WIDTH-1:0] out_dat
);
   localparam int AW = $clog2(DEPTH);
   localparam int PW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;

   // The extra pointer bit separates full from empty; the head reads as zero while empty.
   assign out_vld = (wr_ptr != rd_ptr);
   assign out_dat = out_vld ? mem[rd_ptr[AW-1:0]] : '0;

   // Storage write; the storage itself is not reset because the pointers define validity.
   always_ff @(posedge gclk) begin
      if (in_vld) begin
         mem[wr_ptr[AW-1:0]] <= in_dat;
      end
   end

   // Pointer update: reset empties the FIFO.
   always_ff @(posedge gclk) begin
      if (greset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (in_vld) begin
            wr_ptr <= wr_ptr + PW'(1);
         end
         if (out_vld && out_rdy) begin
            rd_ptr <= rd_ptr + PW'(1);
         end
      end
   end
endmodule

module ram_access_ctrl #(
   parameter int WORD_WIDTH = 8,
   parameter int ADDR_WIDTH = 8,
   parameter int RESP_DEPTH = 4
) (
   input  logic                  gclk,
   input  logic                  greset,
   input  logic                  ReqValid,
   output logic                  ReqReady,
   input  logic                  ReqWrite,
   input  logic [ADDR_WIDTH-1:0] ReqAddr,
   input  logic [WORD_WIDTH-1:0] ReqData,
   output logic                  RespValid,
   input  logic                  RespReady,
   output logic                  RespIsWrite,
   output logic [WORD_WIDTH-1:0] RespData,
   output logic [ADDR_WIDTH-1:0] RamReadAddr,
   output logic [ADDR_WIDTH-1:0] RamWriteAddr,
   output logic [WORD_WIDTH-1:0] RamWriteData,
   output logic                  RamWriteEnable,
   input  logic [WORD_WIDTH-1:0] RamReadData
);
   localparam int CNT_W = $clog2(RESP_DEPTH) + 1;
   localparam logic [CNT_W-1:0] CREDIT_MAX = CNT_W'(RESP_DEPTH);
`ifdef WRITE_ACK_EN
   localparam int FW = WORD_WIDTH + 1;
`else
   localparam int FW = WORD_WIDTH;
`endif

   logic [CNT_W-1:0] outstanding;
   logic             req_acc;
   logic             resp_pop;
   logic             credit_inc;
   logic             issue_rd_vld;
   logic             ret_rd_vld;
   logic             push_vld;
   logic [FW-1:0]    push_dat;
   logic [FW-1:0]    head_dat;

   // Credits cover every response that can still land in the FIFO, so a push never meets a full FIFO.
   assign ReqReady = !greset && (outstanding < CREDIT_MAX);
   assign req_acc  = ReqValid && ReqReady;
   assign resp_pop = RespValid && RespReady;

`ifdef WRITE_ACK_EN
   logic                  ret_wr_vld;
   logic [WORD_WIDTH-1:0] ret_wr_dat;

   assign credit_inc  = req_acc;
   // The ack slot trails the write by one cycle so it lands where a load issued at the same point would return.
   assign push_vld    = ret_rd_vld || ret_wr_vld;
   assign push_dat    = ret_wr_vld ? {1'b1, ret_wr_dat} : {1'b0, RamReadData};
   assign RespIsWrite = head_dat[WORD_WIDTH];
   assign RespData    = head_dat[WORD_WIDTH-1:0];

   // Write-ack return stage, aligned with the load return slot.
   always_ff @(posedge gclk) begin
      if (greset) begin
         ret_wr_vld <= 1'b0;
         ret_wr_dat <= '0;
      end else begin
         ret_wr_vld <= RamWriteEnable;
         ret_wr_dat <= RamWriteData;
      end
   end
`else
   assign credit_inc  = req_acc && !ReqWrite;
   assign push_vld    = ret_rd_vld;
   assign push_dat    = RamReadData;
   assign RespIsWrite = 1'b0;
   assign RespData    = head_dat;
`endif

   // Issue stage drives the RAM from registers; the return bit follows the RAM's one-cycle read latency.
   always_ff @(posedge gclk) begin
      if (greset) begin
         RamWriteEnable <= 1'b0;
         RamWriteAddr   <= '0;
         RamWriteData   <= '0;
         RamReadAddr    <= '0;
         issue_rd_vld   <= 1'b0;
         ret_rd_vld     <= 1'b0;
      end else begin
         RamWriteEnable <= req_acc && ReqWrite;
         issue_rd_vld   <= req_acc && !ReqWrite;
         ret_rd_vld     <= issue_rd_vld;
         if (req_acc && ReqWrite) begin
            RamWriteAddr <= ReqAddr;
            RamWriteData <= ReqData;
         end
         if (req_acc && !ReqWrite) begin
            RamReadAddr <= ReqAddr;
         end
      end
   end

   // Outstanding-response counter; a simultaneous accept and pop cancel out.
   always_ff @(posedge gclk) begin
      if (greset) begin
         outstanding <= '0;
      end else if (credit_inc && !resp_pop) begin
         outstanding <= outstanding + CNT_W'(1);
      end else if (!credit_inc && resp_pop) begin
         outstanding <= outstanding - CNT_W'(1);
      end
   end

   ram_access_ctrl_fifo #(
      .WIDTH (FW),
      .DEPTH (RESP_DEPTH)
   ) u_resp_fifo (
      .gclk    (gclk),
      .greset  (greset),
      .in_vld  (push_vld),
      .in_dat  (push_dat),
      .out_vld (RespValid),
      .out_rdy (RespReady),
      .out_dat (head_dat)
   );
endmodule

// File: tb/tb_ram_access_ctrl.sv
// Testbench for ram_access_ctrl: a behavioural RAM, a reference memory and a response scoreboard.
module tb_ram_access_ctrl;
   logic       gclk;
   logic       greset;
   logic       ReqValid;
   logic       ReqReady;
   logic       ReqWrite;
   logic [7:0] ReqAddr;
   logic [7:0] ReqData;
   logic       RespValid;
   logic       RespReady;
   logic       RespIsWrite;
   logic [7:0] RespData;
   logic [7:0] RamReadAddr;
   logic [7:0] RamWriteAddr;
   logic [7:0] RamWriteData;
   logic       RamWriteEnable;
   logic [7:0] RamReadData;

   logic       preload;
   logic [7:0] ram [256];
   logic [7:0] ref_mem [256];
   logic [8:0] sb [$];
   int         checks = 0;
   int         errors = 0;
   int         resp_count = 0;

`ifdef WRITE_ACK_EN
   localparam int ACK_RESP = 1;
`else
   localparam int ACK_RESP = 0;
`endif

   ram_access_ctrl #(
      .WORD_WIDTH (8),
      .ADDR_WIDTH (8),
      .RESP_DEPTH (4)
   ) dut (
      .gclk           (gclk),
      .greset         (greset),
      .ReqValid       (ReqValid),
      .ReqReady       (ReqReady),
      .ReqWrite       (ReqWrite),
      .ReqAddr        (ReqAddr),
      .ReqData        (ReqData),
      .RespValid      (RespValid),
      .RespReady      (RespReady),
      .RespIsWrite    (RespIsWrite),
      .RespData       (RespData),
      .RamReadAddr    (RamReadAddr),
      .RamWriteAddr   (RamWriteAddr),
      .RamWriteData   (RamWriteData),
      .RamWriteEnable (RamWriteEnable),
      .RamReadData    (RamReadData)
   );

   initial begin
      gclk = 1'b0;
      forever #5 gclk = ~gclk;
   end

   // Behavioural synchronous RAM: no reset, registered read data.
   always @(posedge gclk) begin
      if (preload) begin
         for (int i = 0; i < 256; i++) ram[i] <= 8'(i) ^ 8'hFF;
      end else if (RamWriteEnable) begin
         ram[RamWriteAddr] <= RamWriteData;
      end
      RamReadData <= ram[RamReadAddr];
   end

   // Scoreboard: expectations pushed at accept, compared at every pop.
   always @(negedge gclk) begin
      if (preload) begin
         for (int i = 0; i < 256; i++) ref_mem[i] = 8'(i) ^ 8'hFF;
      end
      if (greset) begin
         sb.delete();
      end else begin
         if (RespValid && RespReady) begin
            checks++;
            resp_count++;
            if (sb.size() == 0) begin
               errors++;
               $display("FAIL stale_resp: got iswr=%0b data=%02h, required no response", RespIsWrite, RespData);
            end else begin
               logic [8:0] exp;
               exp = sb.pop_front();
               if ({RespIsWrite, RespData} !== exp) begin
                  errors++;
                  $display("FAIL resp_order: got iswr=%0b data=%02h, required iswr=%0b data=%02h",
                           RespIsWrite, RespData, exp[8], exp[7:0]);
               end
            end
         end
         if (ReqValid && ReqReady) begin
            if (ReqWrite) begin
               ref_mem[ReqAddr] = ReqData;
               if (ACK_RESP == 1) sb.push_back({1'b1, ReqData});
            end else begin
               sb.push_back({1'b0, ref_mem[ReqAddr]});
            end
         end
      end
   end

   task automatic wait_drain(output bit ok);
      ok = 1'b0;
      for (int n = 0; n < 100; n++) begin
         @(posedge gclk); #2;
         if (sb.size() == 0) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic test_reset();
      greset = 1'b1; preload = 1'b1;
      ReqValid = 1'b0; ReqWrite = 1'b0; ReqAddr = '0; ReqData = '0; RespReady = 1'b1;
      @(posedge gclk); #1;
      @(negedge gclk);
      checks++; if (ReqReady !== 1'b0) begin errors++; $display("FAIL rst_reqready: got %b, required 0", ReqReady); end
      checks++; if (RespValid !== 1'b0) begin errors++; $display("FAIL rst_respvalid: got %b, required 0", RespValid); end
      checks++; if (RespIsWrite !== 1'b0) begin errors++; $display("FAIL rst_respiswrite: got %b, required 0", RespIsWrite); end
      checks++; if (RespData !== 8'h00) begin errors++; $display("FAIL rst_respdata: got %02h, required 00", RespData); end
      checks++; if (RamWriteEnable !== 1'b0) begin errors++; $display("FAIL rst_we: got %b, required 0", RamWriteEnable); end
      checks++; if (RamReadAddr !== 8'h00) begin errors++; $display("FAIL rst_raddr: got %02h, required 00", RamReadAddr); end
      checks++; if (RamWriteAddr !== 8'h00) begin errors++; $display("FAIL rst_waddr: got %02h, required 00", RamWriteAddr); end
      checks++; if (RamWriteData !== 8'h00) begin errors++; $display("FAIL rst_wdata: got %02h, required 00", RamWriteData); end
      @(posedge gclk); #1;
      greset = 1'b0; preload = 1'b0;
      @(negedge gclk);
      checks++; if (ReqReady !== 1'b1) begin errors++; $display("FAIL rst_ready_after: got %b, required 1", ReqReady); end
   endtask

   task automatic test_store_load();
      bit ok;
      RespReady = 1'b1;
      @(posedge gclk); #1;
      ReqValid = 1'b1; ReqWrite = 1'b1; ReqAddr = 8'h10; ReqData = 8'h5A;
      @(negedge gclk);
      checks++; if (ReqReady !== 1'b1) begin errors++; $display("FAIL sl_store_ready: got %b, required 1", ReqReady); end
      @(posedge gclk); #1;
      ReqWrite = 1'b0;
      @(negedge gclk);
      checks++; if ({RamWriteEnable, RamWriteAddr, RamWriteData} !== {1'b1, 8'h10, 8'h5A}) begin
         errors++; $display("FAIL sl_write_port: got we=%b a=%02h d=%02h, required we=1 a=10 d=5a", RamWriteEnable, RamWriteAddr, RamWriteData);
      end
      @(posedge gclk); #1;
      ReqValid = 1'b0;
      @(negedge gclk);
      checks++; if (RamWriteEnable !== 1'b0) begin errors++; $display("FAIL sl_we_one_cycle: got %b, required 0", RamWriteEnable); end
      checks++; if (RamReadAddr !== 8'h10) begin errors++; $display("FAIL sl_read_addr: got %02h, required 10", RamReadAddr); end
      @(posedge gclk); #1;
      @(negedge gclk);
      if (ACK_RESP == 1) begin
         checks++; if ({RespValid, RespIsWrite, RespData} !== {1'b1, 1'b1, 8'h5A}) begin
            errors++; $display("FAIL sl_ack_slot: got v=%b w=%b d=%02h, required v=1 w=1 d=5a", RespValid, RespIsWrite, RespData);
         end
      end else begin
         checks++; if (RespValid !== 1'b0) begin errors++; $display("FAIL sl_early_resp: got %b, required 0", RespValid); end
      end
      @(posedge gclk); #1;
      @(negedge gclk);
      checks++; if ({RespValid, RespIsWrite, RespData} !== {1'b1, 1'b0, 8'h5A}) begin
         errors++; $display("FAIL sl_load_resp: got v=%b w=%b d=%02h, required v=1 w=0 d=5a", RespValid, RespIsWrite, RespData);
      end
      wait_drain(ok);
      checks++; if (ok !== 1'b1) begin errors++; $display("FAIL sl_drain: got %b, required 1", ok); end
   endtask

   task automatic test_back_to_back();
      bit ok;
      int drops;
      int base;
      drops = 0; base = resp_count;
      RespReady = 1'b1; ReqValid = 1'b1; ReqWrite = 1'b0;
      for (int i = 0; i < 8; i++) begin
         ReqAddr = 8'(i);
         @(negedge gclk);
         if (!ReqReady) drops++;
         @(posedge gclk); #1;
      end
      ReqValid = 1'b0;
      checks++; if (drops !== 0) begin errors++; $display("FAIL b2b_ready_drops: got %0d, required 0", drops); end
      wait_drain(ok);
      checks++; if (!ok || (resp_count - base) !== 8) begin
         errors++; $display("FAIL b2b_count: got %0d responses, required 8", resp_count - base);
      end
   endtask

   task automatic test_backpressure();
      bit ok;
      bit took;
      int acc;
      int n;
      acc = 0; n = 0;
      RespReady = 1'b0; ReqValid = 1'b1; ReqWrite = 1'b0; ReqAddr = 8'h20;
      for (int c = 0; c < 10; c++) begin
         @(negedge gclk);
         took = ReqValid && ReqReady;
         @(posedge gclk); #1;
         if (took) begin
            acc++; ReqAddr = 8'h20 + 8'(acc);
            if (acc == 6) ReqValid = 1'b0;
         end
      end
      @(negedge gclk);
      checks++; if (acc !== 4) begin errors++; $display("FAIL bp_accepted: got %0d, required 4", acc); end
      checks++; if (ReqReady !== 1'b0) begin errors++; $display("FAIL bp_ready_low: got %b, required 0", ReqReady); end
      checks++; if ({RespValid, RespData} !== {1'b1, 8'hDF}) begin
         errors++; $display("FAIL bp_head_hold: got v=%b d=%02h, required v=1 d=df", RespValid, RespData);
      end
      @(posedge gclk); #1;
      RespReady = 1'b1;
      while (acc < 6 && n < 40) begin
         @(negedge gclk);
         took = ReqValid && ReqReady;
         @(posedge gclk); #1;
         if (took) begin
            acc++; ReqAddr = 8'h20 + 8'(acc);
            if (acc == 6) ReqValid = 1'b0;
         end
         n++;
      end
      checks++; if (acc !== 6) begin errors++; $display("FAIL bp_rest_accepted: got %0d, required 6", acc); end
      wait_drain(ok);
      checks++; if (ok !== 1'b1) begin errors++; $display("FAIL bp_drain: got %b, required 1", ok); end
   endtask

   task automatic test_pop_accept();
      bit ok;
      RespReady = 1'b0; ReqValid = 1'b1; ReqWrite = 1'b0;
      for (int i = 0; i < 4; i++) begin
         ReqAddr = 8'h60 + 8'(i);
         @(posedge gclk); #1;
      end
      ReqValid = 1'b0;
      repeat (4) begin @(posedge gclk); #1; end
      ReqValid = 1'b1; ReqAddr = 8'h64; RespReady = 1'b1;
      @(negedge gclk);
      checks++; if ({ReqReady, RespValid} !== 2'b01) begin
         errors++; $display("FAIL pa_full: got ready=%b valid=%b, required ready=0 valid=1", ReqReady, RespValid);
      end
      @(posedge gclk); #1;
      @(negedge gclk);
      checks++; if (ReqReady !== 1'b1) begin errors++; $display("FAIL pa_after_pop: got %b, required 1", ReqReady); end
      @(posedge gclk); #1;
      ReqAddr = 8'h65; RespReady = 1'b0;
      @(negedge gclk);
      checks++; if (ReqReady !== 1'b1) begin errors++; $display("FAIL pa_same_cycle: got %b, required 1", ReqReady); end
      @(posedge gclk); #1;
      ReqValid = 1'b0;
      @(negedge gclk);
      checks++; if (ReqReady !== 1'b0) begin errors++; $display("FAIL pa_refull: got %b, required 0", ReqReady); end
      repeat (3) begin @(posedge gclk); #1; end
      @(negedge gclk);
      checks++; if ({ReqReady, RespValid, RespData} !== {1'b0, 1'b1, 8'h9D}) begin
         errors++; $display("FAIL pa_hold: got ready=%b v=%b d=%02h, required ready=0 v=1 d=9d", ReqReady, RespValid, RespData);
      end
      @(posedge gclk); #1;
      RespReady = 1'b1;
      wait_drain(ok);
      checks++; if (ok !== 1'b1) begin errors++; $display("FAIL pa_drain: got %b, required 1", ok); end
   endtask

   task automatic test_reset_inflight();
      bit ok;
      int stale;
      stale = 0;
      RespReady = 1'b0; ReqValid = 1'b1; ReqWrite = 1'b0;
      for (int i = 0; i < 3; i++) begin
         ReqAddr = 8'h30 + 8'(i);
         @(posedge gclk); #1;
      end
      ReqWrite = 1'b1; ReqAddr = 8'h40; ReqData = 8'h77;
      @(posedge gclk); #1;
      ReqValid = 1'b0; ReqWrite = 1'b0; greset = 1'b1;
      @(negedge gclk);
      checks++; if (RamWriteEnable !== 1'b1) begin errors++; $display("FAIL ri_we_in_reset: got %b, required 1", RamWriteEnable); end
      @(posedge gclk); #1;
      greset = 1'b0;
      @(negedge gclk);
      checks++; if ({RespValid, RamWriteEnable, ReqReady} !== 3'b001) begin
         errors++; $display("FAIL ri_after_edge: got v=%b we=%b ready=%b, required v=0 we=0 ready=1", RespValid, RamWriteEnable, ReqReady);
      end
      RespReady = 1'b1;
      for (int c = 0; c < 6; c++) begin
         @(negedge gclk);
         if (RespValid !== 1'b0) stale++;
      end
      checks++; if (stale !== 0) begin errors++; $display("FAIL ri_stale_cycles: got %0d, required 0", stale); end
      @(posedge gclk); #1;
      ReqValid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         ReqAddr = 8'h30 + 8'(i);
         @(posedge gclk); #1;
      end
      ReqAddr = 8'h40;
      @(posedge gclk); #1;
      ReqValid = 1'b0;
      wait_drain(ok);
      checks++; if (ok !== 1'b1) begin errors++; $display("FAIL ri_readback_drain: got %b, required 1", ok); end
   endtask

   task automatic test_write_ack();
      bit ok;
      int base;
      base = resp_count;
      RespReady = 1'b1; ReqValid = 1'b1; ReqWrite = 1'b1; ReqAddr = 8'h50; ReqData = 8'h33;
      @(posedge gclk); #1;
      ReqWrite = 1'b0;
      @(posedge gclk); #1;
      ReqValid = 1'b0;
      wait_drain(ok);
      repeat (3) begin @(posedge gclk); #1; end
      checks++; if (!ok || (resp_count - base) !== 1 + ACK_RESP) begin
         errors++; $display("FAIL wa_resp_count: got %0d, required %0d", resp_count - base, 1 + ACK_RESP);
      end
   endtask

   initial begin
      test_reset();
      test_store_load();
      test_back_to_back();
      test_backpressure();
      test_pop_accept();
      test_reset_inflight();
      test_write_ack();
      repeat (4) begin @(posedge gclk); #1; end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
